// File: rtl/tx_beam_sequencer.sv
// Multi-channel transmit beam sequencer: latches a delay/mask/pulse profile,
// fires delayed shaped pulses as a programmable burst, drives the T/R switch
// and hands the A-line off to receive through a complete/next handshake.
module tx_beam_sequencer #(
    parameter int NUM_CH    = 8,
    parameter int DELAY_W   = 16,
    parameter int PULSE_LEN = 32,
    parameter int BURST_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CH-1:0]           ch_enable,
    input  logic [PULSE_LEN-1:0]        pulse_shape,
    input  logic [NUM_CH*DELAY_W-1:0]   delay_flat,
    input  logic [BURST_W-1:0]          burst_count,
    input  logic [DELAY_W-1:0]          burst_gap,
    input  logic                        load_cfg,
    input  logic                        start_transmit,
    input  logic                        next_aline,
    input  logic                        abort,
    output logic [NUM_CH-1:0]           tx_out,
    output logic                        transmit_in_progress,
    output logic                        transmit_complete,
    output logic                        switch,
    output logic [BURST_W-1:0]          burst_index,
    output logic                        cfg_error
);

    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    // Wide enough for max_delay + PULSE_LEN - 1 without wrapping.
    localparam int TW = DELAY_W + $clog2(PULSE_LEN) + 1;

    typedef enum logic [1:0] {IDLE, FIRE, GAP, DONE} state_t;

    state_t state, state_n;

    // Shadow configuration
    logic [NUM_CH-1:0]               en_sh;
    logic [PULSE_LEN-1:0]            shape_sh;
    logic [NUM_CH-1:0][DELAY_W-1:0]  delay_sh;
    logic [BURST_W-1:0]              cnt_sh;
    logic [DELAY_W-1:0]              gap_sh;
    logic [DELAY_W-1:0]              maxd_sh;
    logic                            cfg_valid;

    logic [TW-1:0]        t, t_n, t_last;
    logic [DELAY_W-1:0]   gap_cnt, gap_n;
    logic [BURST_W-1:0]   bidx_n;
    logic [BURST_W:0]     eff_cnt;
    logic                 err_n;
    logic [DELAY_W-1:0]   max_in;
    logic [NUM_CH-1:0]    tx_n;
    logic [PULSE_LEN-1:0] shape_rev;

    // Largest delay among channels enabled in the incoming config
    always_comb begin
        max_in = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_enable[i] && delay_flat[i*DELAY_W +: DELAY_W] > max_in)
                max_in = delay_flat[i*DELAY_W +: DELAY_W];
        end
    end

    // Shadow config capture; only IDLE accepts a load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_sh     <= '0;
            shape_sh  <= '0;
            delay_sh  <= '0;
            cnt_sh    <= '0;
            gap_sh    <= '0;
            maxd_sh   <= '0;
            cfg_valid <= 1'b0;
        end else if (load_cfg && state == IDLE) begin
            en_sh     <= ch_enable;
            shape_sh  <= pulse_shape;
            for (int i = 0; i < NUM_CH; i++)
                delay_sh[i] <= delay_flat[i*DELAY_W +: DELAY_W];
            cnt_sh    <= burst_count;
            gap_sh    <= burst_gap;
            maxd_sh   <= max_in;
            cfg_valid <= 1'b1;
        end
    end

    assign t_last  = TW'(maxd_sh) + TW'(PULSE_LEN - 1);
    assign eff_cnt = (cnt_sh == '0) ? (BURST_W+1)'(1) : {1'b0, cnt_sh};

    // Next-state, counters and error pulse
    always_comb begin
        state_n = state;
        t_n     = t;
        gap_n   = gap_cnt;
        bidx_n  = burst_index;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start_transmit && !load_cfg) begin
                    if (cfg_valid && en_sh != '0) begin
                        state_n = FIRE;
                        t_n     = '0;
                        bidx_n  = '0;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            FIRE: begin
                if (t == t_last) begin
                    if ({1'b0, burst_index} + (BURST_W+1)'(1) < eff_cnt) begin
                        if (gap_sh == '0) begin
                            t_n    = '0;
                            bidx_n = burst_index + BURST_W'(1);
                        end else begin
                            state_n = GAP;
                            gap_n   = '0;
                        end
                    end else begin
                        state_n = DONE;
                    end
                end else begin
                    t_n = t + TW'(1);
                end
            end
            GAP: begin
                // Index advances as the next burst starts firing
                if (gap_cnt == gap_sh - DELAY_W'(1)) begin
                    state_n = FIRE;
                    t_n     = '0;
                    bidx_n  = burst_index + BURST_W'(1);
                end else begin
                    gap_n = gap_cnt + DELAY_W'(1);
                end
            end
            DONE: begin
                if (next_aline) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (abort && state != IDLE) state_n = IDLE;
        if (state_n == IDLE) bidx_n = '0;
    end

    // Reverse so pattern bit PULSE_LEN-1 is offset 0
    for (genvar j = 0; j < PULSE_LEN; j++) begin : g_rev
        assign shape_rev[j] = shape_sh[PULSE_LEN-1-j];
    end

    // Per-channel pulse bit for the upcoming cycle
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [TW-1:0] rel;
        assign rel     = t_n - TW'(delay_sh[i]);
        assign tx_n[i] = (state_n == FIRE) && en_sh[i] &&
                         (t_n >= TW'(delay_sh[i])) && (rel < TW'(PULSE_LEN)) &&
                         shape_rev[rel[PW-1:0]];
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= IDLE;
            t                    <= '0;
            gap_cnt              <= '0;
            burst_index          <= '0;
            tx_out               <= '0;
            transmit_in_progress <= 1'b0;
            transmit_complete    <= 1'b0;
            switch               <= 1'b0;
            cfg_error            <= 1'b0;
        end else begin
            state                <= state_n;
            t                    <= t_n;
            gap_cnt              <= gap_n;
            burst_index          <= bidx_n;
            tx_out               <= tx_n;
            transmit_in_progress <= (state_n == FIRE) || (state_n == GAP);
            switch               <= (state_n == FIRE) || (state_n == GAP);
            transmit_complete    <= (state_n == DONE);
            cfg_error            <= err_n;
        end
    end

endmodule

// File: tb/tb_tx_beam_sequencer.sv
// Directed bench for tx_beam_sequencer: inputs driven and outputs sampled on
// the falling edge, so each sample shows the state after the last rising edge.
module tb_tx_beam_sequencer;

    localparam int NUM_CH = 8, DELAY_W = 16, PULSE_LEN = 32, BURST_W = 4;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NUM_CH-1:0]         ch_enable = '0;
    logic [PULSE_LEN-1:0]      pulse_shape = '0;
    logic [NUM_CH*DELAY_W-1:0] delay_flat = '0;
    logic [BURST_W-1:0]        burst_count = '0;
    logic [DELAY_W-1:0]        burst_gap = '0;
    logic                      load_cfg = 1'b0, start_transmit = 1'b0;
    logic                      next_aline = 1'b0, abort = 1'b0;
    logic [NUM_CH-1:0]         tx_out;
    logic                      transmit_in_progress, transmit_complete, switch, cfg_error;
    logic [BURST_W-1:0]        burst_index;

    int checks = 0;
    int errors = 0;

    logic [31:0] pat  = 32'h5BBDF7EB;
    logic [7:0]  mask = 8'b10100101;
    int          dly [8] = '{6, 6, 4, 4, 2, 2, 0, 0};

    tx_beam_sequencer #(.NUM_CH(NUM_CH), .DELAY_W(DELAY_W), .PULSE_LEN(PULSE_LEN),
                        .BURST_W(BURST_W)) dut (
        .clk(clk), .rst(rst), .ch_enable(ch_enable), .pulse_shape(pulse_shape),
        .delay_flat(delay_flat), .burst_count(burst_count), .burst_gap(burst_gap),
        .load_cfg(load_cfg), .start_transmit(start_transmit), .next_aline(next_aline),
        .abort(abort), .tx_out(tx_out), .transmit_in_progress(transmit_in_progress),
        .transmit_complete(transmit_complete), .switch(switch),
        .burst_index(burst_index), .cfg_error(cfg_error)
    );

    always #5 clk = ~clk;

    // Expected tx_out for FIRE cycle t of the reference profile
    function automatic logic [7:0] exp_tx(input int t);
        logic [7:0] r = '0;
        for (int i = 0; i < 8; i++)
            if (mask[i] && t >= dly[i] && t - dly[i] < 32) r[i] = pat[31 - (t - dly[i])];
        return r;
    endfunction

    task automatic load(input logic [7:0] m, input logic [3:0] cnt, input logic [15:0] gap);
        @(negedge clk);
        ch_enable = m; pulse_shape = pat; burst_count = cnt; burst_gap = gap;
        for (int i = 0; i < 8; i++) delay_flat[i*16 +: 16] = 16'(dly[i]);
        load_cfg = 1'b1;
        @(negedge clk);
        load_cfg = 1'b0;
    endtask

    // Returns at the falling edge inside FIRE cycle t=0
    task automatic pulse_start;
        @(negedge clk); start_transmit = 1'b1;
        @(negedge clk); start_transmit = 1'b0;
    endtask

    task automatic ack;
        next_aline = 1'b1; @(negedge clk); next_aline = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            ch_enable = 8'($urandom); load_cfg = 1'($urandom); start_transmit = 1'($urandom);
            next_aline = 1'($urandom); abort = 1'($urandom); burst_count = 4'($urandom);
            @(negedge clk);
            checks++;
            if ({tx_out, transmit_in_progress, transmit_complete, switch, burst_index, cfg_error} !== '0) begin
                errors++; $display("FAIL reset_hold got %h want 0", {tx_out, transmit_in_progress, transmit_complete, switch, burst_index, cfg_error});
            end
        end
        ch_enable = '0; load_cfg = 0; start_transmit = 0; next_aline = 0; abort = 0; burst_count = 0;
        @(negedge clk); rst = 1'b1;
        pulse_start;
        checks++;
        if (cfg_error !== 1'b1 || transmit_in_progress !== 1'b0) begin
            errors++; $display("FAIL reset_noload_err got err=%b ip=%b want 1 0", cfg_error, transmit_in_progress);
        end
        @(negedge clk);
        checks++;
        if (cfg_error !== 1'b0) begin errors++; $display("FAIL err_one_cycle got %b want 0", cfg_error); end
    endtask

    task automatic test_collision;
        @(negedge clk);
        ch_enable = mask; pulse_shape = pat; burst_count = 1; burst_gap = 0;
        for (int i = 0; i < 8; i++) delay_flat[i*16 +: 16] = 16'(dly[i]);
        load_cfg = 1'b1; start_transmit = 1'b1;
        @(negedge clk);
        load_cfg = 1'b0; start_transmit = 1'b0;
        checks++;
        if (transmit_in_progress !== 1'b0 || cfg_error !== 1'b0) begin
            errors++; $display("FAIL collision_nofire got ip=%b err=%b want 0 0", transmit_in_progress, cfg_error);
        end
        pulse_start;
        repeat (7) @(negedge clk);
        checks++;
        if (transmit_in_progress !== 1'b1 || tx_out !== exp_tx(7)) begin
            errors++; $display("FAIL collision_latched got ip=%b tx=%h want 1 %h", transmit_in_progress, tx_out, exp_tx(7));
        end
        abort = 1'b1; @(negedge clk); abort = 1'b0;
    endtask

    task automatic test_single_burst;
        load(mask, 1, 0);
        pulse_start;
        for (int k = 0; k < 38; k++) begin
            checks++;
            if (tx_out !== exp_tx(k) || transmit_in_progress !== 1'b1 || switch !== 1'b1) begin
                errors++; $display("FAIL single_t%0d got tx=%h ip=%b sw=%b want %h 1 1", k, tx_out, transmit_in_progress, switch, exp_tx(k));
            end
            @(negedge clk);
        end
        checks++;
        if (transmit_complete !== 1'b1 || switch !== 1'b0 || transmit_in_progress !== 1'b0 || tx_out !== '0) begin
            errors++; $display("FAIL single_done got c=%b sw=%b ip=%b tx=%h want 1 0 0 00", transmit_complete, switch, transmit_in_progress, tx_out);
        end
        ack;
        checks++;
        if (transmit_complete !== 1'b0) begin errors++; $display("FAIL single_ack got %b want 0", transmit_complete); end
    endtask

    task automatic test_burst;
        load(mask, 2, 3);
        pulse_start;
        for (int k = 0; k < 79; k++) begin
            logic [7:0] e;
            logic [3:0] bi;
            e  = (k < 38) ? exp_tx(k) : (k < 41) ? 8'h00 : exp_tx(k - 41);
            bi = (k < 41) ? 4'd0 : 4'd1;
            checks++;
            if (tx_out !== e || transmit_in_progress !== 1'b1 || burst_index !== bi) begin
                errors++; $display("FAIL burst_c%0d got tx=%h ip=%b bi=%0d want %h 1 %0d", k, tx_out, transmit_in_progress, burst_index, e, bi);
            end
            @(negedge clk);
        end
        repeat (3) begin
            checks++;
            if (transmit_complete !== 1'b1 || transmit_in_progress !== 1'b0) begin
                errors++; $display("FAIL burst_done_hold got c=%b ip=%b want 1 0", transmit_complete, transmit_in_progress);
            end
            @(negedge clk);
        end
        ack;
        checks++;
        if (transmit_complete !== 1'b0) begin errors++; $display("FAIL burst_ack got %b want 0", transmit_complete); end
        pulse_start;
        repeat (6) @(negedge clk);
        checks++;
        if (transmit_in_progress !== 1'b1 || tx_out !== exp_tx(6)) begin
            errors++; $display("FAIL burst_restart got ip=%b tx=%h want 1 %h", transmit_in_progress, tx_out, exp_tx(6));
        end
        abort = 1'b1; @(negedge clk); abort = 1'b0;
    endtask

    task automatic test_zero_gap_count;
        int n;
        logic [3:0] b38, b76;
        load(mask, 0, 3);
        pulse_start;
        n = 0;
        while (transmit_in_progress === 1'b1 && n < 300) begin n++; @(negedge clk); end
        checks++;
        if (n !== 38 || transmit_complete !== 1'b1) begin
            errors++; $display("FAIL count0_len got %0d c=%b want 38 1", n, transmit_complete);
        end
        ack;
        load(mask, 3, 0);
        pulse_start;
        n = 0; b38 = 'x; b76 = 'x;
        while (transmit_in_progress === 1'b1 && n < 300) begin
            if (n == 38) begin
                b38 = burst_index;
                checks++;
                if (tx_out !== exp_tx(0)) begin errors++; $display("FAIL gap0_b2t0 got %h want %h", tx_out, exp_tx(0)); end
            end
            if (n == 76) b76 = burst_index;
            n++; @(negedge clk);
        end
        checks++;
        if (n !== 114 || b38 !== 4'd1 || b76 !== 4'd2) begin
            errors++; $display("FAIL gap0_len got n=%0d b38=%0d b76=%0d want 114 1 2", n, b38, b76);
        end
        ack;
    endtask

    task automatic test_abort_reset;
        load(mask, 1, 0);
        pulse_start;
        repeat (10) @(negedge clk);
        abort = 1'b1; next_aline = 1'b1;
        @(negedge clk);
        abort = 1'b0; next_aline = 1'b0;
        repeat (3) begin
            checks++;
            if (tx_out !== '0 || switch !== 1'b0 || transmit_in_progress !== 1'b0 || transmit_complete !== 1'b0) begin
                errors++; $display("FAIL abort_idle got tx=%h sw=%b ip=%b c=%b want 00 0 0 0", tx_out, switch, transmit_in_progress, transmit_complete);
            end
            @(negedge clk);
        end
        pulse_start;
        repeat (10) @(negedge clk);
        checks++;
        if (switch !== 1'b1) begin errors++; $display("FAIL pre_rst_switch got %b want 1", switch); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (tx_out !== '0 || switch !== 1'b0 || transmit_in_progress !== 1'b0) begin
            errors++; $display("FAIL async_rst got tx=%h sw=%b ip=%b want 00 0 0", tx_out, switch, transmit_in_progress);
        end
        @(negedge clk); rst = 1'b1;
        pulse_start;
        checks++;
        if (cfg_error !== 1'b1 || transmit_in_progress !== 1'b0) begin
            errors++; $display("FAIL rst_clears_cfg got err=%b ip=%b want 1 0", cfg_error, transmit_in_progress);
        end
    endtask

    task automatic test_mask_zero;
        load(8'h00, 1, 0);
        pulse_start;
        checks++;
        if (cfg_error !== 1'b1 || transmit_in_progress !== 1'b0 || switch !== 1'b0) begin
            errors++; $display("FAIL mask0 got err=%b ip=%b sw=%b want 1 0 0", cfg_error, transmit_in_progress, switch);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_collision;
        test_single_burst;
        test_burst;
        test_zero_gap_count;
        test_mask_zero;
        test_abort_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
